// File: rtl/regfile_wb_scheduler_if.sv
// Bundles the issue-stage, writeback-request and register-file-write signals of the write-port scheduler.
// The slave modport belongs to the scheduler; the master modport belongs to whoever drives it.
interface regfile_wb_scheduler_if #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 32
);
    logic            issue_valid;
    logic [AW-1:0]   issue_rn1;
    logic [AW-1:0]   issue_rn2;
    logic            issue_use1;
    logic            issue_use2;
    logic            issue_we;
    logic [AW-1:0]   issue_wn;
    logic            stall;

    logic            alu_valid;
    logic [AW-1:0]   alu_wn;
    logic [DW-1:0]   alu_wd;
    logic            alu_ready;

    logic            mem_valid;
    logic [AW-1:0]   mem_wn;
    logic [DW-1:0]   mem_wd;
    logic            mem_ready;

    logic            rf_en;
    logic [AW-1:0]   rf_wn;
    logic [DW-1:0]   rf_wd;
    logic [NREG-1:0] busy;

    modport slave (
        input  issue_valid, issue_rn1, issue_rn2, issue_use1, issue_use2, issue_we, issue_wn,
        input  alu_valid, alu_wn, alu_wd, mem_valid, mem_wn, mem_wd,
        output stall, alu_ready, mem_ready, rf_en, rf_wn, rf_wd, busy
    );

    modport master (
        output issue_valid, issue_rn1, issue_rn2, issue_use1, issue_use2, issue_we, issue_wn,
        output alu_valid, alu_wn, alu_wd, mem_valid, mem_wn, mem_wd,
        input  stall, alu_ready, mem_ready, rf_en, rf_wn, rf_wd, busy
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the single register-file write port (ALU vs load writeback)
// plus a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int DW   = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    regfile_wb_scheduler_if.slave bus
);
    logic            last_mem;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_nxt;
    logic            rf_en_q;
    logic [AW-1:0]   rf_wn_q;
    logic [DW-1:0]   rf_wd_q;

    logic            contested;
    logic            grant_alu;
    logic            grant_mem;
    logic            wb_en;
    logic [AW-1:0]   wb_wn;
    logic [DW-1:0]   wb_wd;
    logic            stall_c;
    logic            set_en;

    // Stall looks only at registered busy; a clear on this edge is not bypassed.
    always_comb begin
        stall_c = bus.issue_valid &&
                  ((bus.issue_use1 && busy_q[bus.issue_rn1]) ||
                   (bus.issue_use2 && busy_q[bus.issue_rn2]) ||
                   (bus.issue_we   && busy_q[bus.issue_wn]));
    end

    // last_mem=1 means the load path won the previous contest, so the ALU goes next.
    always_comb begin
        contested = bus.alu_valid && bus.mem_valid;
        grant_alu = bus.alu_valid && (!bus.mem_valid || last_mem);
        grant_mem = bus.mem_valid && (!bus.alu_valid || !last_mem);
        wb_en     = grant_alu || grant_mem;
        wb_wn     = grant_mem ? bus.mem_wn : bus.alu_wn;
        wb_wd     = grant_mem ? bus.mem_wd : bus.alu_wd;
        set_en    = bus.issue_valid && bus.issue_we && !stall_c;

        // Clear first, then set, so a same-edge set of the same register wins.
        busy_nxt = busy_q;
        if (wb_en) begin
            busy_nxt[wb_wn] = 1'b0;
        end
        if (set_en) begin
            busy_nxt[bus.issue_wn] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_mem <= 1'b1;
            busy_q   <= '0;
            rf_en_q  <= 1'b0;
            rf_wn_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            busy_q  <= busy_nxt;
            rf_en_q <= wb_en;
            if (contested) begin
                last_mem <= grant_mem;
            end
            if (wb_en) begin
                rf_wn_q <= wb_wn;
                rf_wd_q <= wb_wd;
            end
        end
    end

    assign bus.stall     = stall_c;
    assign bus.alu_ready = grant_alu;
    assign bus.mem_ready = grant_mem;
    assign bus.rf_en     = rf_en_q;
    assign bus.rf_wn     = rf_wn_q;
    assign bus.rf_wd     = rf_wd_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed scenarios followed by randomized traffic checked against a register-level
// behavioural model of the write-port scheduler and busy scoreboard.
module tb_regfile_wb_scheduler;
    localparam int NREG = 16;
    localparam int AW   = 4;
    localparam int DW   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.NREG(NREG), .AW(AW), .DW(DW)) bus ();

    regfile_wb_scheduler #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          mb [NREG];
    bit          mem_won_last;
    bit          exp_en;
    logic [AW-1:0] exp_wn;
    logic [DW-1:0] exp_wd;

    // Random-phase request state
    bit          ap, mp, ga, gm, both, exp_stall;
    logic [AW-1:0] awn, mwn;
    logic [DW-1:0] awd, mwd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.issue_valid = 0; bus.issue_rn1 = 0; bus.issue_rn2 = 0;
        bus.issue_use1  = 0; bus.issue_use2 = 0; bus.issue_we = 0; bus.issue_wn = 0;
        bus.alu_valid = 0; bus.alu_wn = 0; bus.alu_wd = 0;
        bus.mem_valid = 0; bus.mem_wn = 0; bus.mem_wd = 0;
    endtask

    task automatic issue(input bit v, input int rn1, input bit u1, input int rn2, input bit u2,
                         input bit we, input int wn);
        bus.issue_valid = v;
        bus.issue_rn1 = AW'(rn1); bus.issue_use1 = u1;
        bus.issue_rn2 = AW'(rn2); bus.issue_use2 = u2;
        bus.issue_we = we; bus.issue_wn = AW'(wn);
    endtask

    function automatic logic [NREG-1:0] model_busy();
        logic [NREG-1:0] b;
        for (int i = 0; i < NREG; i++) b[i] = mb[i];
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mb[i] = 0;
        mem_won_last = 1;
        exp_en = 0; exp_wn = 0; exp_wd = 0;
    endtask

    initial begin
        idle();
        model_reset();

        // Reset with idle inputs
        step(); step();
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_rf_en", 32'(bus.rf_en), 32'h0);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_rf_wn", 32'(bus.rf_wn), 32'h0);
        check("rst_rf_wd", bus.rf_wd, 32'h0);
        rst_n = 1;
        step();

        // Single ALU writeback
        bus.alu_valid = 1; bus.alu_wn = 3; bus.alu_wd = 32'hDEAD_BEEF;
        #1;
        check("alu_ready", 32'(bus.alu_ready), 32'h1);
        check("alu_mem_ready", 32'(bus.mem_ready), 32'h0);
        step();
        bus.alu_valid = 0;
        check("alu_rf_en", 32'(bus.rf_en), 32'h1);
        check("alu_rf_wn", 32'(bus.rf_wn), 32'h3);
        check("alu_rf_wd", bus.rf_wd, 32'hDEAD_BEEF);
        step();
        check("alu_rf_en_drop", 32'(bus.rf_en), 32'h0);
        check("alu_rf_wn_hold", 32'(bus.rf_wn), 32'h3);

        // Contested arbitration: expect ALU, MEM, ALU, MEM
        bus.alu_valid = 1; bus.alu_wn = 1; bus.alu_wd = 32'h1111_0001;
        bus.mem_valid = 1; bus.mem_wn = 2; bus.mem_wd = 32'h2222_0002;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("arb_alu_ready", 32'(bus.alu_ready), 32'((k % 2) == 0));
            check("arb_mem_ready", 32'(bus.mem_ready), 32'((k % 2) == 1));
            step();
            check("arb_rf_wn", 32'(bus.rf_wn), ((k % 2) == 0) ? 32'd1 : 32'd2);
            check("arb_rf_en", 32'(bus.rf_en), 32'h1);
        end
        idle();
        step();

        // RAW stall on r5 until the load writeback to r5 lands
        issue(1, 0, 0, 0, 0, 1, 5);
        #1;
        check("raw_set_stall", 32'(bus.stall), 32'h0);
        step();
        check("raw_busy_set", 32'(bus.busy), 32'h0020);
        issue(1, 5, 1, 0, 0, 0, 0);
        #1;
        check("raw_stall_a", 32'(bus.stall), 32'h1);
        step();
        check("raw_stall_b", 32'(bus.stall), 32'h1);
        bus.mem_valid = 1; bus.mem_wn = 5; bus.mem_wd = 32'h5555_AAAA;
        #1;
        check("raw_mem_ready", 32'(bus.mem_ready), 32'h1);
        check("raw_no_bypass", 32'(bus.stall), 32'h1);
        step();
        bus.mem_valid = 0;
        check("raw_stall_clear", 32'(bus.stall), 32'h0);
        check("raw_busy_clear", 32'(bus.busy), 32'h0);
        check("raw_rf_wn", 32'(bus.rf_wn), 32'h5);
        check("raw_rf_wd", bus.rf_wd, 32'h5555_AAAA);
        idle();
        step();

        // WAW stall and set-wins-over-clear
        issue(1, 0, 0, 0, 0, 1, 7);
        step();
        check("waw_busy7", 32'(bus.busy), 32'h0080);
        #1;
        check("waw_stall", 32'(bus.stall), 32'h1);
        step();
        check("waw_no_set", 32'(bus.busy), 32'h0080);
        issue(1, 0, 0, 0, 0, 1, 9);
        bus.alu_valid = 1; bus.alu_wn = 9; bus.alu_wd = 32'h0000_0009;
        #1;
        check("setwins_stall", 32'(bus.stall), 32'h0);
        step();
        check("setwins_busy", 32'(bus.busy), 32'h0280);
        // Stray writeback to a non-busy register is still written, busy unchanged
        issue(0, 0, 0, 0, 0, 0, 0);
        bus.alu_wn = 2; bus.alu_wd = 32'h0000_0022;
        step();
        check("stray_rf_en", 32'(bus.rf_en), 32'h1);
        check("stray_rf_wn", 32'(bus.rf_wn), 32'h2);
        check("stray_busy", 32'(bus.busy), 32'h0280);
        // Set r5 while clearing r9 to reach 0x00A0 with a write in flight
        issue(1, 0, 0, 0, 0, 1, 5);
        bus.alu_wn = 9; bus.alu_wd = 32'h9999_9999;
        step();
        idle();
        check("pre_rst_busy", 32'(bus.busy), 32'h00A0);
        check("pre_rst_rf_en", 32'(bus.rf_en), 32'h1);

        // Asynchronous reset between edges
        #2;
        rst_n = 0;
        #1;
        check("async_rf_en", 32'(bus.rf_en), 32'h0);
        check("async_busy", 32'(bus.busy), 32'h0);
        check("async_rf_wn", 32'(bus.rf_wn), 32'h0);
        step();
        rst_n = 1;
        model_reset();
        step();
        check("post_rst_rf_en", 32'(bus.rf_en), 32'h0);

        // Unused operands never stall
        issue(1, 0, 0, 0, 0, 1, 4);
        step();
        issue(1, 4, 0, 4, 0, 0, 0);
        #1;
        check("unused_stall", 32'(bus.stall), 32'h0);
        bus.issue_use2 = 1;
        #1;
        check("use2_stall", 32'(bus.stall), 32'h1);
        idle();

        // Fresh reset, then randomized traffic against the model
        rst_n = 0;
        step();
        rst_n = 1;
        model_reset();
        ap = 0; mp = 0;
        awn = 0; mwn = 0; awd = 0; mwd = 0;
        step();
        for (int c = 0; c < 400; c++) begin
            if (!ap && $urandom_range(0, 2) != 0) begin
                ap = 1; awn = AW'($urandom_range(0, 7)); awd = $urandom;
            end
            if (!mp && $urandom_range(0, 2) != 0) begin
                mp = 1; mwn = AW'($urandom_range(0, 7)); mwd = $urandom;
            end
            bus.alu_valid = ap; bus.alu_wn = awn; bus.alu_wd = awd;
            bus.mem_valid = mp; bus.mem_wn = mwn; bus.mem_wd = mwd;
            issue($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 7));

            exp_stall = bus.issue_valid &&
                        ((bus.issue_use1 && mb[bus.issue_rn1]) ||
                         (bus.issue_use2 && mb[bus.issue_rn2]) ||
                         (bus.issue_we   && mb[bus.issue_wn]));
            both = ap && mp;
            if (both) begin
                ga = mem_won_last;
                gm = !mem_won_last;
            end else begin
                ga = ap;
                gm = mp;
            end
            #1;
            check("rnd_stall", 32'(bus.stall), 32'(exp_stall));
            check("rnd_alu_ready", 32'(bus.alu_ready), 32'(ga));
            check("rnd_mem_ready", 32'(bus.mem_ready), 32'(gm));

            step();
            exp_en = ga || gm;
            if (ga) begin
                mb[awn] = 0; exp_wn = awn; exp_wd = awd; ap = 0;
            end else if (gm) begin
                mb[mwn] = 0; exp_wn = mwn; exp_wd = mwd; mp = 0;
            end
            if (bus.issue_valid && bus.issue_we && !exp_stall) mb[bus.issue_wn] = 1;
            if (both) mem_won_last = gm;

            check("rnd_rf_en", 32'(bus.rf_en), 32'(exp_en));
            check("rnd_rf_wn", 32'(bus.rf_wn), 32'(exp_wn));
            check("rnd_rf_wd", bus.rf_wd, exp_wd);
            check("rnd_busy", 32'(bus.busy), 32'(model_busy()));
        end

        idle();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
